ahb_boot_loader: RTL and testbench

AHB-Lite master that loads a program image from a byte stream into the on-chip program RAM, then releases the Cortex-M0 from reset. It sits between a byte-stream receiver (e.g. UART RX) and the AHB-Lite bus, and owns the bus while the CPU is held in reset. Each assembled 32-bit word is written with a single NONSEQ word transfer, and the RAM's write wait state is honoured through HREADY.

---
 rtl/ahb_boot_loader.sv | 134 +++++++++++++
 tb/tb_ahb_boot_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_boot_loader.sv
// AHB-Lite boot loader: turns a little-endian byte stream into word writes to program RAM,
// then releases the CPU from reset. Define BOOT_CHECKSUM_EN to require a trailing checksum byte.
module ahb_boot_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          WORD_COUNT = 4096
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        HREADY,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  output logic        cpu_reset_n,
  output logic        done,
  output logic        error
);
  // One extra index bit so a full-capacity image does not wrap the counter.
  localparam int IDX_W = $clog2(WORD_COUNT) + 1;

  localparam logic [2:0] S_LEN0    = 3'd0;
  localparam logic [2:0] S_LEN1    = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_ADDR    = 3'd3;
  localparam logic [2:0] S_DATA    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERROR   = 3'd7;
`ifdef BOOT_CHECKSUM_EN
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_END     = S_CHECK;
`else
  localparam logic [2:0] S_END     = S_DONE;
`endif

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [15:0]      len;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [31:0]      word;
  logic [1:0]       byte_cnt;
  logic             accept;
  logic [15:0]      len_full;
  logic             last_word;
  logic             next_accepts;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign accept    = rx_valid && rx_ready;
  assign len_full  = {rx_data, len[7:0]};
  assign idx_next  = idx + IDX_W'(1);
  assign last_word = (32'(idx_next) == 32'(len));
  assign HSIZE     = 3'b010;

  always_comb begin
    next_state = state;
    case (state)
      S_LEN0:    if (accept) next_state = S_LEN1;
      S_LEN1: begin
        if (accept) begin
          if (32'(len_full) > 32'(WORD_COUNT)) next_state = S_ERROR;
          else if (len_full == 16'd0)          next_state = S_END;
          else                                 next_state = S_COLLECT;
        end
      end
      S_COLLECT: if (accept && byte_cnt == 2'd3) next_state = S_ADDR;
      S_ADDR:    if (HREADY) next_state = S_DATA;
      S_DATA:    if (HREADY) next_state = last_word ? S_END : S_COLLECT;
`ifdef BOOT_CHECKSUM_EN
      S_CHECK:   if (accept) next_state = (rx_data == csum) ? S_DONE : S_ERROR;
`endif
      default:   next_state = state;
    endcase
  end

  always_comb begin
    next_accepts = (next_state == S_LEN0) || (next_state == S_LEN1) || (next_state == S_COLLECT);
`ifdef BOOT_CHECKSUM_EN
    if (next_state == S_CHECK) next_accepts = 1'b1;
`endif
  end

  // Bus and handshake outputs are registered from the state being entered.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= S_LEN0;
      len         <= '0;
      idx         <= '0;
      word        <= '0;
      byte_cnt    <= '0;
      rx_ready    <= 1'b0;
      HTRANS      <= TRANS_IDLE;
      HWRITE      <= 1'b0;
      HADDR       <= BASE_ADDR;
      HWDATA      <= '0;
      cpu_reset_n <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      state    <= next_state;
      rx_ready <= next_accepts;
      HTRANS   <= (next_state == S_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
      HWRITE   <= (next_state == S_ADDR);
      if (state == S_LEN0 && accept) len[7:0]  <= rx_data;
      if (state == S_LEN1 && accept) len[15:8] <= rx_data;
      if (state == S_COLLECT && accept) begin
        word     <= {rx_data, word[31:8]};
        byte_cnt <= byte_cnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
        csum     <= csum + rx_data;
`endif
      end
      if (state == S_COLLECT && next_state == S_ADDR) HADDR <= BASE_ADDR + (32'(idx) << 2);
      if (state == S_ADDR && HREADY) HWDATA <= word;
      if (state == S_DATA && HREADY) idx <= idx_next;
      if (next_state == S_DONE) begin
        done        <= 1'b1;
        cpu_reset_n <= 1'b1;
      end
      if (next_state == S_ERROR) error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ahb_boot_loader.sv
// Randomized bench for ahb_boot_loader: drives byte streams and wait states, compares the
// observed AHB writes and final status with a stream-level model of the load.
module tb_ahb_boot_loader;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          WC   = 16;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        cpu_reset_n;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  logic [7:0]  stream[$];
  logic [31:0] img_words[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  bit          exp_done;
  bit          exp_err;
  int          len_cyc, fin_cyc, err_cyc, done_cyc;

  ahb_boot_loader #(.BASE_ADDR(BASE), .WORD_COUNT(WC)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .HREADY(HREADY), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .cpu_reset_n(cpu_reset_n),
    .done(done), .error(error)
  );

  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    HREADY   = 1'b1;
    HRESETn  = 1'b0;
    #1;
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("rst_htrans", 32'(HTRANS), 32'd0);
    checkOutput("rst_hwrite", 32'(HWRITE), 32'd0);
    checkOutput("rst_hsize", 32'(HSIZE), 32'd2);
    checkOutput("rst_haddr", HADDR, BASE);
    checkOutput("rst_hwdata", HWDATA, 32'd0);
    checkOutput("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    checkOutput("rst_rx_ready_up", 32'(rx_ready), 32'd1);
  endtask

  // Model: the stream format and the writes/outcome it must produce, built from img_words.
  task automatic buildStream(input int n, input logic [7:0] csum_xor);
    logic [7:0]  s;
    logic [7:0]  by;
    logic [31:0] w;
    s = 8'h00;
    stream.delete();
    exp_addr.delete();
    exp_data.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    exp_err  = (n > WC) || (CSUM && csum_xor != 8'h00);
    exp_done = !exp_err;
    if (n <= WC) begin
      for (int i = 0; i < n; i++) begin
        w = img_words[i];
        for (int b = 0; b < 4; b++) begin
          by = w[8*b +: 8];
          stream.push_back(by);
          s = s + by;
        end
        exp_addr.push_back(BASE + 32'(4 * i));
        exp_data.push_back(w);
      end
      if (CSUM) stream.push_back(s ^ csum_xor);
    end
  endtask

  task automatic randomWords(input int n);
    img_words.delete();
    for (int i = 0; i < n; i++) img_words.push_back($urandom);
  endtask

  // mode 0: random valid/ready, 1: back-to-back zero-wait, 2: 3-cycle stall per bus phase.
  task automatic applyStimulus(input int mode, input int abort_after);
    int          ptr = 0;
    int          cyc = 0;
    int          post = 0;
    int          budget;
    int          stall_left = 0;
    bit          in_phase = 0;
    bit          acc;
    bit          data_pend = 0;
    bit          addr_stall = 0;
    bit          data_stall = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] held_addr = '0;
    logic [31:0] held_data = '0;
    logic [1:0]  held_trans = '0;
    logic        held_write = 1'b0;
    budget = 20 * stream.size() + 200;
    got_addr.delete();
    got_data.delete();
    len_cyc = -1; fin_cyc = -1; err_cyc = -1; done_cyc = -1;
    forever begin
      if (ptr < stream.size() && ptr != abort_after) begin
        rx_valid = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        rx_data  = stream[ptr];
      end else begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end
      if (mode == 0) HREADY = ($urandom_range(0, 2) != 0);
      else if (mode == 1) HREADY = 1'b1;
      else begin
        if ((HTRANS == 2'b10 || data_pend) && !in_phase) begin
          in_phase   = 1'b1;
          stall_left = 3;
        end
        HREADY = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end

      @(negedge HCLK);
      acc = rx_valid && rx_ready;
      checkOutput("cpu_rst_vs_done", 32'(cpu_reset_n), 32'(done));
      if (data_pend) begin
        if (data_stall) checkOutput("hwdata_hold", HWDATA, held_data);
        checkOutput("rx_ready_data", 32'(rx_ready), 32'd0);
        if (HREADY) begin
          got_addr.push_back(pend_addr);
          got_data.push_back(HWDATA);
          data_pend  = 1'b0;
          data_stall = 1'b0;
        end else begin
          data_stall = 1'b1;
          held_data  = HWDATA;
        end
      end
      if (HTRANS != 2'b00) begin
        if (addr_stall) begin
          checkOutput("haddr_hold", HADDR, held_addr);
          checkOutput("htrans_hold", 32'(HTRANS), 32'(held_trans));
          checkOutput("hwrite_hold", 32'(HWRITE), 32'(held_write));
        end
        checkOutput("htrans_kind", 32'(HTRANS), 32'd2);
        checkOutput("hwrite_addr", 32'(HWRITE), 32'd1);
        checkOutput("rx_ready_addr", 32'(rx_ready), 32'd0);
        if (HREADY) begin
          data_pend  = 1'b1;
          pend_addr  = HADDR;
          addr_stall = 1'b0;
        end else begin
          addr_stall = 1'b1;
          held_addr  = HADDR;
          held_trans = HTRANS;
          held_write = HWRITE;
        end
      end else if (addr_stall) begin
        checkOutput("htrans_hold", 32'(HTRANS), 32'(held_trans));
        addr_stall = 1'b0;
      end
      if (mode == 2 && in_phase && HREADY) in_phase = 1'b0;

      @(posedge HCLK);
      #1;
      cyc++;
      if (acc) begin
        ptr++;
        if (ptr == 2) len_cyc = cyc;
        if (ptr == stream.size()) fin_cyc = cyc;
      end
      if (error && err_cyc < 0) err_cyc = cyc;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (abort_after >= 0 && ptr == abort_after) break;
      if (done || error) post++;
      if (post >= 4) break;
      if (cyc > budget) begin
        checkOutput("timeout", 32'(cyc), 32'(budget));
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic checkResults(input string tag);
    checkOutput({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
      checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
    end
    checkOutput({tag, "_done"}, 32'(done), 32'(exp_done));
    checkOutput({tag, "_error"}, 32'(error), 32'(exp_err));
    checkOutput({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'(exp_done));
    checkOutput({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    checkOutput({tag, "_htrans"}, 32'(HTRANS), 32'd0);
    checkOutput({tag, "_hsize"}, 32'(HSIZE), 32'd2);
  endtask

  initial begin
    int          n;
    logic [7:0]  cx;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    HREADY   = 1'b1;
    #3;
    doReset();

    $display("[TB] single word load");
    img_words.delete();
    img_words.push_back(32'hDEADBEEF);
    buildStream(1, 8'h00);
    applyStimulus(1, -1);
    checkResults("one");
    checkOutput("one_latency", 32'(done_cyc - fin_cyc), CSUM ? 32'd0 : 32'd2);

    if (CSUM) begin
      $display("[TB] bad checksum");
      doReset();
      buildStream(1, 8'h38);
      applyStimulus(1, -1);
      checkResults("badsum");
    end

    $display("[TB] stalled bus phases");
    doReset();
    randomWords(2);
    buildStream(2, 8'h00);
    applyStimulus(2, -1);
    checkResults("stall");

    $display("[TB] oversize image");
    doReset();
    buildStream(WC + 1, 8'h00);
    applyStimulus(1, -1);
    checkResults("ovs");
    checkOutput("ovs_err_timing", 32'(err_cyc), 32'(len_cyc));

    $display("[TB] empty image");
    doReset();
    buildStream(0, 8'h00);
    applyStimulus(1, -1);
    checkResults("empty");

    $display("[TB] full capacity image");
    doReset();
    randomWords(WC);
    buildStream(WC, 8'h00);
    applyStimulus(0, -1);
    checkResults("full");

    for (int t = 0; t < 6; t++) begin
      doReset();
      n = $urandom_range(1, 5);
      randomWords(n);
      cx = (CSUM && $urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      buildStream(n, cx);
      applyStimulus(0, -1);
      checkResults($sformatf("rand%0d", t));
    end

    $display("[TB] reset during load");
    doReset();
    randomWords(1);
    buildStream(1, 8'h00);
    applyStimulus(1, 4);
    checkOutput("abort_nwrites", 32'(got_addr.size()), 32'd0);
    doReset();
    randomWords(1);
    buildStream(1, 8'h00);
    applyStimulus(1, -1);
    checkResults("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
